// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels, optional
// first-word-fall-through output, error strobes and an exact occupancy count.
module sync_fifo_prog #(
  parameter int unsigned DATA_WIDTH              = 64,
  parameter int unsigned ADDR_WIDTH              = 9,
  parameter int unsigned ALMOST_FULL_OFFSET      = 128,
  parameter int unsigned ALMOST_EMPTY_OFFSET     = 128,
  parameter string       FIRST_WORD_FALL_THROUGH = "FALSE"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam bit          Fwft  = (FIRST_WORD_FALL_THROUGH == "TRUE");

  localparam logic [ADDR_WIDTH:0] DepthCnt = CntW'(Depth);
  localparam logic [ADDR_WIDTH:0] AfLevel  = CntW'(Depth - ALMOST_FULL_OFFSET);
  localparam logic [ADDR_WIDTH:0] AeLevel  = CntW'(ALMOST_EMPTY_OFFSET);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  out_valid_q;
  logic                  wr_err_q, rd_err_q;
  logic                  push_ok, pop_ok, ram_nonempty, ram_rd;

  // In FWFT mode the count includes the word parked in the output register,
  // so the RAM itself holds count - out_valid words.
  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = Fwft ? !out_valid_q : (count_q == '0);
    push_ok      = push && !full;
    pop_ok       = pop && !empty;
    ram_nonempty = Fwft ? (count_q > CntW'(out_valid_q)) : (count_q != '0);
    ram_rd       = Fwft ? (ram_nonempty && (!out_valid_q || pop_ok)) : pop_ok;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      wr_err_q <= push && full;
      rd_err_q <= pop && empty;
      count_q  <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem[rd_ptr_q];
      end
      if (Fwft) begin
        if (ram_rd) begin
          out_valid_q <= 1'b1;
        end else if (pop_ok) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  // Storage is kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = dout_q;
  assign fifo_count   = count_q;
  assign almost_full  = (count_q >= AfLevel);
  assign almost_empty = (count_q <= AeLevel);
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and checks both
// against a queue-based reference model through a scoreboard monitor.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 4;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_empty, s_full, s_ae, s_af, s_werr, s_rerr;
  logic          f_empty, f_full, f_ae, f_af, f_werr, f_rerr;
  logic [AW:0]   s_cnt, f_cnt;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_OFFSET(AF), .ALMOST_EMPTY_OFFSET(AE),
    .FIRST_WORD_FALL_THROUGH("FALSE")
  ) dut_std (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(s_dout), .empty(s_empty), .full(s_full), .almost_empty(s_ae),
    .almost_full(s_af), .fifo_count(s_cnt), .wr_err(s_werr), .rd_err(s_rerr)
  );

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_OFFSET(AF), .ALMOST_EMPTY_OFFSET(AE),
    .FIRST_WORD_FALL_THROUGH("TRUE")
  ) dut_fwft (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(f_dout), .empty(f_empty), .full(f_full), .almost_empty(f_ae),
    .almost_full(f_af), .fifo_count(f_cnt), .wr_err(f_werr), .rd_err(f_rerr)
  );

  typedef struct {
    int       due;
    int       s_cnt;
    bit [5:0] s_flg;
    bit [7:0] s_dout;
    int       f_cnt;
    bit [5:0] f_flg;
    bit [7:0] f_dout;
    bit       f_chk;
  } exp_t;

  typedef struct {
    bit [7:0] d;
    int       e;  // edge at which the word was written
  } fw_ent_t;

  exp_t     expq[$];
  bit [7:0] rdq[$];
  bit [7:0] sq[$];
  fw_ent_t  fq[$];
  bit [7:0] s_out = '0;
  bit [7:0] f_out = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  bit finished = 1'b0;
  bit std_fire = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit [5:0] flags(input int n, input bit emp, input bit we, input bit re);
    return {emp, n == DEPTH, n <= AE, n >= DEPTH - AF, we, re};
  endfunction

  // Model of one clock edge; the expected post-edge state is queued for the monitor.
  task automatic step(input bit ps, input bit pp, input bit [7:0] d, input bit rs);
    exp_t    r;
    fw_ent_t ent;
    bit      s_we, s_re, f_we, f_re, f_emp, f_emp_post;
    @(negedge clk);
    push = ps;
    pop = pp;
    data_in = d;
    reset = rs;
    s_we = 0; s_re = 0; f_we = 0; f_re = 0;
    if (rs) begin
      sq.delete();
      fq.delete();
      s_out = '0;
      f_out = '0;
    end else begin
      s_we = ps && (sq.size() == DEPTH);
      s_re = pp && (sq.size() == 0);
      if (pp && !s_re) begin
        s_out = sq.pop_front();
        rdq.push_back(s_out);
      end
      if (ps && !s_we) sq.push_back(d);

      // A word becomes visible at the output one edge after it was written.
      f_emp = (fq.size() == 0) || (fq[0].e == cyc);
      f_we = ps && (fq.size() == DEPTH);
      f_re = pp && f_emp;
      if (pp && !f_emp) void'(fq.pop_front());
      if (ps && !f_we) begin
        ent.d = d;
        ent.e = cyc + 1;
        fq.push_back(ent);
      end
    end
    f_emp_post = (fq.size() == 0) || (fq[0].e == cyc + 1);
    if (!f_emp_post) f_out = fq[0].d;

    r.due    = cyc + 1;
    r.s_cnt  = sq.size();
    r.s_flg  = flags(sq.size(), sq.size() == 0, s_we, s_re);
    r.s_dout = s_out;
    r.f_cnt  = fq.size();
    r.f_flg  = flags(fq.size(), f_emp_post, f_we, f_re);
    r.f_dout = f_out;
    r.f_chk  = rs || !f_emp_post;
    expq.push_back(r);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) std_fire <= pop && !reset && (s_empty == 1'b0);

  always @(negedge clk) begin
    exp_t     r;
    bit [7:0] w;
    if (std_fire) begin
      if (rdq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL std_read: unexpected read, data_out %0h", s_dout);
      end else begin
        w = rdq.pop_front();
        check("std_read_data", int'(s_dout), int'(w));
      end
    end
    while (expq.size() > 0 && expq[0].due == cyc) begin
      r = expq.pop_front();
      check("std_count", int'(s_cnt), r.s_cnt);
      check("std_flags", int'({s_empty, s_full, s_ae, s_af, s_werr, s_rerr}), int'(r.s_flg));
      check("std_data_out", int'(s_dout), int'(r.s_dout));
      check("fwft_count", int'(f_cnt), r.f_cnt);
      check("fwft_flags", int'({f_empty, f_full, f_ae, f_af, f_werr, f_rerr}), int'(r.f_flg));
      if (r.f_chk) check("fwft_data_out", int'(f_dout), int'(r.f_dout));
    end
    if (done && !finished) begin
      finished = 1'b1;
      check("expect_queue_drained", expq.size(), 0);
      check("read_queue_drained", rdq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    bit [7:0] n;
    int       mode;
    bit       ps, pp;
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    // Fill, overflow, push+pop while full, then drain past empty.
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0);
    step(1, 0, 8'hAA, 0);
    step(1, 1, 8'hAA, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    // Steady state at 8 words across pointer wrap.
    n = 8'h20;
    for (int i = 0; i < 8; i++) begin step(1, 0, n, 0); n++; end
    for (int i = 0; i < 40; i++) begin step(1, 1, n, 0); n++; end
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0);
    // Fall-through latency and back-to-back pops.
    step(1, 0, 8'h5A, 0);
    step(0, 0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0);
    // Reset with traffic in flight.
    for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom), 0);
    step(1, 1, 8'h77, 1);
    step(1, 0, 8'h3C, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    // Randomized traffic with phases biased toward full, empty and balanced.
    for (int i = 0; i < 900; i++) begin
      mode = (i / 64) % 3;
      case (mode)
        0:       begin ps = ($urandom_range(0, 9) < 8); pp = ($urandom_range(0, 9) < 3); end
        1:       begin ps = ($urandom_range(0, 9) < 3); pp = ($urandom_range(0, 9) < 8); end
        default: begin ps = ($urandom_range(0, 9) < 5); pp = ($urandom_range(0, 9) < 5); end
      endcase
      step(ps, pp, 8'($urandom), $urandom_range(0, 199) == 0);
    end
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    @(negedge clk);
    done = 1'b1;
  end

endmodule
